// File: rtl/load_data_aligner.sv
// Load-side data aligner: reads word memory, extracts and extends byte/half/word loads.
// Optional LOAD_SPLIT_EN splits word-crossing loads into two reads and merges them.
module load_data_aligner (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        WAIT0  = 3'd2,
        ISSUE1 = 3'd3,
        WAIT1  = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [1:0]      size_q, size_n;
    logic            uns_q, uns_n;
    logic            req_ready_n;
    logic            mem_re_n;
    logic [AW-1:0]   mem_addr_n;
    logic            rsp_valid_n;
    logic [DW-1:0]   rsp_data_n;
    logic            rsp_err_n;
`ifdef LOAD_SPLIT_EN
    logic [DW-1:0]   word0_q, word0_n;
    logic [DW-1:0]   word1_q, word1_n;
`endif

    // Access crosses a word boundary and needs a second read.
    function automatic logic needs_split(input logic [1:0] off, input logic [1:0] size);
        return (size == 2'b01 && off == 2'b11) || (size == 2'b10 && off != 2'b00);
    endfunction

    function automatic logic [DW-1:0] align(input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                                            input logic [1:0] off);
        logic [2*DW-1:0] cat;
        cat = {hi, lo} >> {off, 3'b000};
        return cat[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] extend(input logic [DW-1:0] raw, input logic [1:0] size,
                                             input logic uns);
        case (size)
            2'b00:   return uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   return uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            req_ready <= 1'b1;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
`ifdef LOAD_SPLIT_EN
            word0_q   <= '0;
            word1_q   <= '0;
`endif
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            size_q    <= size_n;
            uns_q     <= uns_n;
            req_ready <= req_ready_n;
            mem_re    <= mem_re_n;
            mem_addr  <= mem_addr_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
`ifdef LOAD_SPLIT_EN
            word0_q   <= word0_n;
            word1_q   <= word1_n;
`endif
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_n     = state;
        addr_n      = addr_q;
        size_n      = size_q;
        uns_n       = uns_q;
        mem_re_n    = 1'b0;
        mem_addr_n  = mem_addr;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
`ifdef LOAD_SPLIT_EN
        word0_n     = word0_q;
        word1_n     = word1_q;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_n = req_addr;
                    size_n = req_size;
                    uns_n  = req_unsigned;
`ifdef LOAD_SPLIT_EN
                    if (req_size == 2'b11) begin
`else
                    if (req_size == 2'b11 || needs_split(req_addr[1:0], req_size)) begin
`endif
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_data_n  = '0;
                    end else begin
                        state_n    = ISSUE0;
                        mem_re_n   = 1'b1;
                        mem_addr_n = {req_addr[31:2], 2'b00};
                    end
                end
            end
            ISSUE0: state_n = WAIT0;
            WAIT0: begin
`ifdef LOAD_SPLIT_EN
                word0_n = mem_rdata;
                if (needs_split(addr_q[1:0], size_q)) begin
                    state_n    = ISSUE1;
                    mem_re_n   = 1'b1;
                    mem_addr_n = {addr_q[31:2] + 30'd1, 2'b00};
                end else begin
                    word1_n     = '0;
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    rsp_data_n  = extend(align('0, mem_rdata, addr_q[1:0]), size_q, uns_q);
                end
`else
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_data_n  = extend(align('0, mem_rdata, addr_q[1:0]), size_q, uns_q);
`endif
            end
`ifdef LOAD_SPLIT_EN
            ISSUE1: state_n = WAIT1;
            WAIT1: begin
                word1_n     = mem_rdata;
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_data_n  = extend(align(mem_rdata, word0_q, addr_q[1:0]), size_q, uns_q);
            end
`endif
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        req_ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_load_data_aligner.sv
// Directed table-driven bench for load_data_aligner; expectations follow LOAD_SPLIT_EN.
module tb_load_data_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    load_data_aligner dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .mem_re       (mem_re),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    // Word memory model: read data appears the cycle after the strobe.
    logic [31:0] mem [logic [31:0]];
    always @(posedge clk) begin
        if (mem_re)
            mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        else
            mem_rdata <= 32'hDEAD_BEEF;
    end

    logic [31:0] re_q[$];
    always @(negedge clk) if (mem_re) re_q.push_back(mem_addr);

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_reads;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(string name, logic [31:0] addr, logic [1:0] size, logic uns,
                                logic [31:0] w0, logic [31:0] w1, logic [31:0] d, logic e,
                                int lat, int reads, logic [31:0] a0, logic [31:0] a1);
        vec_t v;
        v.name = name; v.addr = addr; v.size = size; v.uns = uns; v.w0 = w0; v.w1 = w1;
        v.exp_data = d; v.exp_err = e; v.exp_lat = lat; v.exp_reads = reads;
        v.exp_a0 = a0; v.exp_a1 = a1;
        return v;
    endfunction

    // Apply one load from a negedge in IDLE and check the complete transaction.
    task automatic run_vec(input vec_t v);
        int          lat;
        bit          seen;
        logic [31:0] wa;
        logic [31:0] held;
        wa = {v.addr[31:2], 2'b00};
        mem[wa]          = v.w0;
        mem[wa + 32'd4]  = v.w1;
        re_q.delete();
        chk({v.name, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_addr     = v.addr;
        req_size     = v.size;
        req_unsigned = v.uns;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (rsp_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no rsp_valid within 20 cycles", v.name);
            return;
        end
        chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, " rsp_data"}, rsp_data, v.exp_data);
        chk({v.name, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        held = rsp_data;
        @(negedge clk);
        chk({v.name, " rsp_valid pulse"}, 32'(rsp_valid), 32'd0);
        chk({v.name, " rsp_data hold"}, rsp_data, held);
        chk({v.name, " reads"}, 32'(re_q.size()), 32'(v.exp_reads));
        if (v.exp_reads >= 1 && re_q.size() >= 1) chk({v.name, " addr0"}, re_q[0], v.exp_a0);
        if (v.exp_reads >= 2 && re_q.size() >= 2) chk({v.name, " addr1"}, re_q[1], v.exp_a1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_unsigned = 1'b0;

        vecs.push_back(mk("lb_s",  32'h0000_0103, 2'b00, 1'b0, 32'h8012_3456, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1, 32'h100, 32'h0));
        vecs.push_back(mk("lbu",   32'h0000_0103, 2'b00, 1'b1, 32'h8012_3456, 32'h0, 32'h0000_0080, 1'b0, 3, 1, 32'h100, 32'h0));
        vecs.push_back(mk("lh_o1", 32'h0000_0011, 2'b01, 1'b0, 32'h009A_BC00, 32'h0, 32'hFFFF_9ABC, 1'b0, 3, 1, 32'h10, 32'h0));
        vecs.push_back(mk("lw",    32'h0000_0040, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0, 3, 1, 32'h40, 32'h0));
        vecs.push_back(mk("lbu_0", 32'h0000_0050, 2'b00, 1'b1, 32'h0000_00F0, 32'h0, 32'h0000_00F0, 1'b0, 3, 1, 32'h50, 32'h0));
        vecs.push_back(mk("lb_1",  32'h0000_0055, 2'b00, 1'b0, 32'h0000_7F00, 32'h0, 32'h0000_007F, 1'b0, 3, 1, 32'h54, 32'h0));
        vecs.push_back(mk("lhu_2", 32'h0000_0062, 2'b01, 1'b1, 32'hBEEF_1234, 32'h0, 32'h0000_BEEF, 1'b0, 3, 1, 32'h60, 32'h0));
        vecs.push_back(mk("lh_2",  32'h0000_0062, 2'b01, 1'b0, 32'hBEEF_1234, 32'h0, 32'hFFFF_BEEF, 1'b0, 3, 1, 32'h60, 32'h0));
        vecs.push_back(mk("ill",   32'h0000_0070, 2'b11, 1'b0, 32'h1111_1111, 32'h0, 32'h0000_0000, 1'b1, 1, 0, 32'h0, 32'h0));
`ifdef LOAD_SPLIT_EN
        vecs.push_back(mk("lw_o2", 32'h0000_0022, 2'b10, 1'b0, 32'hDDCC_BBAA, 32'h4433_2211, 32'h2211_DDCC, 1'b0, 5, 2, 32'h20, 32'h24));
        vecs.push_back(mk("lh_wr", 32'hFFFF_FFFF, 2'b01, 1'b0, 32'h8500_0000, 32'h0000_00F1, 32'hFFFF_F185, 1'b0, 5, 2, 32'hFFFF_FFFC, 32'h0));
        vecs.push_back(mk("lhu_3", 32'h0000_0033, 2'b01, 1'b1, 32'h7700_0000, 32'h0000_0012, 32'h0000_1277, 1'b0, 5, 2, 32'h30, 32'h34));
        vecs.push_back(mk("lw_o1", 32'h0000_0081, 2'b10, 1'b0, 32'h1122_3344, 32'h5566_7788, 32'h8811_2233, 1'b0, 5, 2, 32'h80, 32'h84));
`else
        vecs.push_back(mk("lw_o2", 32'h0000_0002, 2'b10, 1'b0, 32'hDDCC_BBAA, 32'h4433_2211, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
        vecs.push_back(mk("lh_o3", 32'hFFFF_FFFF, 2'b01, 1'b0, 32'h8500_0000, 32'h0000_00F1, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
        vecs.push_back(mk("lw_o1", 32'h0000_0081, 2'b10, 1'b0, 32'h1122_3344, 32'h5566_7788, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
`endif
        vecs.push_back(mk("lw_ok", 32'h0000_0090, 2'b10, 1'b1, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 1, 32'h90, 32'h0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset mem_re",    32'(mem_re), 32'd0);
        chk("reset mem_addr",  mem_addr, 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_data",  rsp_data, 32'd0);
        chk("reset rsp_err",   32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while waiting for read data: response is dropped, next load is clean.
        mem[32'h200] = 32'h5A5A_5A5A;
        req_valid = 1'b1; req_addr = 32'h200; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid mem_re issue", 32'(mem_re), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid mem_re",    32'(mem_re), 32'd0);
        chk("rstmid req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        begin
            int stray = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (rsp_valid) stray++;
            end
            chk("rstmid no response", 32'(stray), 32'd0);
        end
        run_vec(mk("post_rst", 32'h0000_0204, 2'b10, 1'b0, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 1, 32'h204, 32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
